// File: rtl/lcd_write_sequencer.sv
// HD44780-style 8-bit LCD write sequencer: power-up init, char/space/clear writes, cursor tracking.
// Optional feature: define LCD_AUTOWRAP_EN to issue a DDRAM line-change command after column COLS-1.
module lcd_write_sequencer #(
  parameter int unsigned PWRUP_CYC   = 1_500_000,
  parameter int unsigned E_SETUP_CYC = 8,
  parameter int unsigned E_PULSE_CYC = 50,
  parameter int unsigned CMD_CYC     = 5_000,
  parameter int unsigned CLR_CYC     = 200_000,
  parameter int unsigned COLS        = 16
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  input  logic       word_sep,
  input  logic       clear_req,
  output logic       char_ready,
  output logic       busy,
  output logic [7:0] lcd_d,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [4:0] col,
  output logic       line
);

  localparam int unsigned CNT_MAX = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LD_PWRUP = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(E_SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(E_PULSE_CYC - 1);
  localparam logic [CW-1:0] LD_CMD   = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(CLR_CYC - 1);
  localparam logic [4:0]    LAST_COL = 5'(COLS - 1);

  typedef enum logic [2:0] {ST_PWRUP, ST_IDLE, ST_SETUP, ST_PULSE, ST_WAIT} state_t;
  typedef enum logic [1:0] {WK_INIT, WK_DATA, WK_CLEAR, WK_WRAP} kind_t;

  state_t        state, state_nxt;
  kind_t         kind, kind_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    init_idx, init_idx_nxt;
  logic [7:0]    d_nxt;
  logic          rs_nxt;
  logic [4:0]    col_nxt;
  logic          line_nxt;
  logic          clr_pend, clr_pend_nxt;
  logic          start_clear;
  logic          long_cmd;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
  assign long_cmd   = !lcd_rs && (lcd_d[7:2] == 6'd0) && (lcd_d[1:0] != 2'd0);
  assign char_ready = (state == ST_IDLE) && !clr_pend;
  assign busy       = (state != ST_IDLE);
  assign lcd_rw     = 1'b0;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_nxt    = state;
    kind_nxt     = kind;
    cnt_nxt      = (cnt == '0) ? '0 : cnt - 1'b1;
    init_idx_nxt = init_idx;
    d_nxt        = lcd_d;
    rs_nxt       = lcd_rs;
    col_nxt      = col;
    line_nxt     = line;
    start_clear  = 1'b0;

    case (state)
      ST_PWRUP: begin
        if (cnt == '0) begin
          state_nxt    = ST_SETUP;
          cnt_nxt      = LD_SETUP;
          kind_nxt     = WK_INIT;
          init_idx_nxt = 2'd0;
          d_nxt        = init_byte(2'd0);
          rs_nxt       = 1'b0;
        end
      end
      ST_IDLE: begin
        // A clear arriving this very cycle already outranks a simultaneous char.
        if (clr_pend || clear_req) begin
          state_nxt   = ST_SETUP;
          cnt_nxt     = LD_SETUP;
          kind_nxt    = WK_CLEAR;
          d_nxt       = 8'h01;
          rs_nxt      = 1'b0;
          start_clear = 1'b1;
        end else if (char_valid || word_sep) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = LD_SETUP;
          kind_nxt  = WK_DATA;
          d_nxt     = char_valid ? char_in : 8'h20;
          rs_nxt    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = LD_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = long_cmd ? LD_CLR : LD_CMD;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          case (kind)
            WK_INIT: begin
              if (init_idx != 2'd3) begin
                state_nxt    = ST_SETUP;
                cnt_nxt      = LD_SETUP;
                init_idx_nxt = init_idx + 2'd1;
                d_nxt        = init_byte(init_idx + 2'd1);
              end
            end
            WK_DATA: begin
              if (col != LAST_COL) begin
                col_nxt = col + 5'd1;
              end else begin
`ifdef LCD_AUTOWRAP_EN
                state_nxt = ST_SETUP;
                cnt_nxt   = LD_SETUP;
                kind_nxt  = WK_WRAP;
                d_nxt     = line ? 8'h80 : 8'hC0;
                rs_nxt    = 1'b0;
`else
                col_nxt = LAST_COL;
`endif
              end
            end
            WK_CLEAR: begin
              col_nxt  = 5'd0;
              line_nxt = 1'b0;
            end
            default: begin
              col_nxt  = 5'd0;
              line_nxt = ~line;
            end
          endcase
        end
      end
      default: state_nxt = ST_PWRUP;
    endcase
  end

  assign clr_pend_nxt = (clr_pend || clear_req) && !start_clear;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_PWRUP;
      kind     <= WK_INIT;
      cnt      <= LD_PWRUP;
      init_idx <= 2'd0;
      lcd_d    <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      col      <= 5'd0;
      line     <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state    <= state_nxt;
      kind     <= kind_nxt;
      cnt      <= cnt_nxt;
      init_idx <= init_idx_nxt;
      lcd_d    <= d_nxt;
      lcd_rs   <= rs_nxt;
      lcd_e    <= (state_nxt == ST_PULSE);
      col      <= col_nxt;
      line     <= line_nxt;
      clr_pend <= clr_pend_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Scoreboard bench for lcd_write_sequencer: expected LCD writes are queued as stimulus is driven
// and compared against every observed E pulse (rs, data, width, rise time) once the DUT is idle.
module tb_lcd_write_sequencer;

  localparam int PWRUP = 20;
  localparam int ESET  = 2;
  localparam int EPUL  = 3;

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       word_sep = 1'b0;
  logic       clear_req = 1'b0;
  logic       char_ready, busy, lcd_rs, lcd_rw, lcd_e, line;
  logic [7:0] lcd_d;
  logic [4:0] col;

  lcd_write_sequencer #(
    .PWRUP_CYC(PWRUP), .E_SETUP_CYC(ESET), .E_PULSE_CYC(EPUL),
    .CMD_CYC(5), .CLR_CYC(10), .COLS(16)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
    .word_sep(word_sep), .clear_req(clear_req), .char_ready(char_ready), .busy(busy),
    .lcd_d(lcd_d), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .col(col), .line(line)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {logic rs; logic [7:0] d; int rise;} exp_t;
  typedef struct {logic rs; logic [7:0] d; int rise; int width;} obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   rd_idx = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   col_m = 0;
  logic line_m = 1'b0;

  always @(posedge sysclk) cyc <= cyc + 1;

  // E-pulse monitor: the only writer of obs_q; aborted pulses (reset) are discarded.
  initial begin : monitor
    obs_t cur;
    logic in_pulse;
    in_pulse = 1'b0;
    cur = '{rs: 1'b0, d: 8'h00, rise: 0, width: 0};
    forever begin
      @(negedge sysclk);
      if (!rst_n) begin
        in_pulse = 1'b0;
      end else if (lcd_e && !in_pulse) begin
        in_pulse = 1'b1;
        cur = '{rs: lcd_rs, d: lcd_d, rise: cyc, width: 1};
      end else if (lcd_e) begin
        cur.width++;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        obs_q.push_back(cur);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic rs, input logic [7:0] d, input int rise);
    exp_q.push_back('{rs: rs, d: d, rise: rise});
  endtask

  task automatic push_init(input int release_cyc);
    push_exp(1'b0, 8'h38, release_cyc + PWRUP + ESET);
    push_exp(1'b0, 8'h0C, -1);
    push_exp(1'b0, 8'h06, -1);
    push_exp(1'b0, 8'h01, -1);
  endtask

  // Cursor model for one data write, including the optional wrap command.
  task automatic model_data_write();
    if (col_m == 15) begin
`ifdef LCD_AUTOWRAP_EN
      push_exp(1'b0, line_m ? 8'h80 : 8'hC0, -1);
      col_m = 0;
      line_m = ~line_m;
`endif
    end else begin
      col_m++;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!char_ready && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    checks++;
    if (!char_ready) begin
      errors++;
      $display("FAIL %s: char_ready still low after %0d cycles", tag, budget);
    end
  endtask

  task automatic check_writes(input string tag);
    obs_t o;
    exp_t e;
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      errors++;
      $display("FAIL %s write count: got %0d expected %0d", tag, obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0 && rd_idx < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[rd_idx];
      rd_idx++;
      checks++;
      if ({o.rs, o.d} !== {e.rs, e.d}) begin
        errors++;
        $display("FAIL %s write: got rs=%0b d=%02h expected rs=%0b d=%02h", tag, o.rs, o.d, e.rs, e.d);
      end
      checks++;
      if (o.width != EPUL) begin
        errors++;
        $display("FAIL %s e_width: got %0d expected %0d", tag, o.width, EPUL);
      end
      if (e.rise >= 0) begin
        checks++;
        if (o.rise != e.rise) begin
          errors++;
          $display("FAIL %s e_rise: got cycle %0d expected %0d", tag, o.rise, e.rise);
        end
      end
    end
    exp_q.delete();
    rd_idx = obs_q.size();
  endtask

  task automatic check_cursor(input string tag);
    checks++;
    if ({line, col} !== {line_m, 5'(col_m)}) begin
      errors++;
      $display("FAIL %s cursor: got line=%0b col=%0d expected line=%0b col=%0d", tag, line, col, line_m, col_m);
    end
  endtask

  // Drives one char (or word separator) request in IDLE and models its effect.
  task automatic send(input string tag, input logic sep, input logic [7:0] c);
    wait_idle(tag, 200);
    if (sep) word_sep = 1'b1;
    else begin
      char_valid = 1'b1;
      char_in = c;
    end
    push_exp(1'b1, sep ? 8'h20 : c, cyc + ESET + 1);
    model_data_write();
    @(negedge sysclk);
    char_valid = 1'b0;
    word_sep = 1'b0;
    char_in = 8'hFF;
    checks++;
    if (busy !== 1'b1 || char_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_accept: got busy=%0b ready=%0b expected 1/0", tag, busy, char_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sysclk);
    checks++;
    if ({lcd_d, lcd_rs, lcd_rw, lcd_e, col, line, busy, char_ready} !== {8'h00, 3'b000, 5'd0, 1'b0, 2'b10}) begin
      errors++;
      $display("FAIL reset outputs: got d=%02h rs=%0b rw=%0b e=%0b col=%0d line=%0b busy=%0b ready=%0b expected zeros busy=1",
               lcd_d, lcd_rs, lcd_rw, lcd_e, col, line, busy, char_ready);
    end
  endtask

  task automatic test_init();
    rst_n = 1'b1;
    col_m = 0;
    line_m = 1'b0;
    push_init(cyc);
    @(negedge sysclk);
    wait_idle("init", 400);
    check_writes("init");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL init busy: got %0b expected 0", busy);
    end
    check_cursor("init");
  endtask

  task automatic test_char();
    send("char", 1'b0, 8'h41);
    wait_idle("char", 200);
    check_writes("char");
    check_cursor("char");
  endtask

  task automatic test_word_sep();
    send("word_sep", 1'b1, 8'h00);
    wait_idle("word_sep", 200);
    check_writes("word_sep");
    check_cursor("word_sep");
  endtask

  task automatic test_char_beats_sep();
    word_sep = 1'b1;
    send("char_vs_sep", 1'b0, 8'h62);
    wait_idle("char_vs_sep", 200);
    check_writes("char_vs_sep");
    check_cursor("char_vs_sep");
  endtask

  task automatic test_drop_while_busy();
    send("drop", 1'b0, 8'h42);
    char_valid = 1'b1;
    char_in = 8'h43;
    @(negedge sysclk);
    char_valid = 1'b0;
    word_sep = 1'b1;
    @(negedge sysclk);
    word_sep = 1'b0;
    wait_idle("drop", 200);
    check_writes("drop");
    check_cursor("drop");
  endtask

  task automatic test_clear_priority();
    wait_idle("clear_prio", 200);
    char_valid = 1'b1;
    char_in = 8'h5A;
    clear_req = 1'b1;
    push_exp(1'b0, 8'h01, cyc + ESET + 1);
    col_m = 0;
    line_m = 1'b0;
    @(negedge sysclk);
    char_valid = 1'b0;
    clear_req = 1'b0;
    wait_idle("clear_prio", 200);
    check_writes("clear_prio");
    check_cursor("clear_prio");
  endtask

  task automatic test_line_fill();
    for (int i = 0; i < 16; i++) send("fill0", 1'b0, 8'h61 + 8'(i));
    wait_idle("fill0", 200);
    check_writes("fill0");
    check_cursor("fill0");
`ifdef LCD_AUTOWRAP_EN
    for (int i = 0; i < 16; i++) send("fill1", 1'b0, 8'h41 + 8'(i));
`else
    send("fill1", 1'b0, 8'h7A);
`endif
    wait_idle("fill1", 200);
    check_writes("fill1");
    check_cursor("fill1");
  endtask

  task automatic test_clear_in_pwrup();
    test_reset();
    rst_n = 1'b1;
    col_m = 0;
    line_m = 1'b0;
    push_init(cyc);
    push_exp(1'b0, 8'h01, -1);
    repeat (4) @(negedge sysclk);
    clear_req = 1'b1;
    @(negedge sysclk);
    clear_req = 1'b0;
    wait_idle("clear_pwrup", 400);
    check_writes("clear_pwrup");
    check_cursor("clear_pwrup");
  endtask

  task automatic test_reset_mid_pulse();
    int n;
    send("rst_mid", 1'b0, 8'h55);
    n = 0;
    while (!lcd_e && n < 50) begin
      @(negedge sysclk);
      n++;
    end
    checks++;
    if (!lcd_e) begin
      errors++;
      $display("FAIL rst_mid e_seen: lcd_e never rose within 50 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({lcd_e, busy, lcd_d, lcd_rs} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid outputs: got e=%0b busy=%0b d=%02h rs=%0b expected 0/1/00/0", lcd_e, busy, lcd_d, lcd_rs);
    end
    repeat (3) @(negedge sysclk);
    exp_q.delete();
    rd_idx = obs_q.size();
    test_init();
  endtask

  initial begin
    test_reset();
    test_init();
    test_char();
    test_word_sep();
    test_char_beats_sep();
    test_drop_while_busy();
    test_clear_priority();
    test_line_fill();
    test_clear_in_pwrup();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
